// File: rtl/counter_module.sv
// N-bit up/down wrap-around counter with enable.
// Single-cycle overflow/underflow pulses are registered alongside the count.
module counter_module #(
   parameter int unsigned N = 8
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Count_en,
   input  logic         Up_Down_Ctrl,
   output logic [N-1:0] Count_out,
   output logic         Overflow_intr,
   output logic         Underflow_intr
);

   localparam logic [N-1:0] COUNT_MAX = {N{1'b1}};
   localparam logic [N-1:0] COUNT_ONE = N'(1);

   logic [N-1:0] count_nxt;
   logic         overflow_nxt;
   logic         underflow_nxt;

   // Next count and wrap detection from the current registered value
   always_comb begin
      count_nxt     = Count_out;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
      if (Count_en) begin
         if (!Up_Down_Ctrl) begin
            count_nxt    = Count_out + COUNT_ONE;
            overflow_nxt = (Count_out == COUNT_MAX);
         end else begin
            count_nxt     = Count_out - COUNT_ONE;
            underflow_nxt = (Count_out == '0);
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Count_out      <= '0;
         Overflow_intr  <= 1'b0;
         Underflow_intr <= 1'b0;
      end else begin
         Count_out      <= count_nxt;
         Overflow_intr  <= overflow_nxt;
         Underflow_intr <= underflow_nxt;
      end
   end

endmodule

// File: tb/tb_counter_module.sv
// Bench for counter_module: a 17-bit and a 4-bit instance share stimulus and
// are checked every cycle against an arithmetic model, plus literal checkpoints.
module tb_counter_module;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        en    = 1'b1;
   logic        dn    = 1'b0;
   logic [16:0] c17;
   logic        ov17, un17;
   logic [3:0]  c4;
   logic        ov4, un4;

   int vectors     = 0;
   int miscompares = 0;
   bit check_on    = 1'b0;

   // Model state: plain integers modulo 2^N
   int m17 = 0, m17_ov = 0, m17_un = 0;
   int m4  = 0, m4_ov  = 0, m4_un  = 0;

   always #5 clock = ~clock;

   counter_module #(.N(17)) dut17 (
      .Clock(clock), .Reset(reset), .Count_en(en), .Up_Down_Ctrl(dn),
      .Count_out(c17), .Overflow_intr(ov17), .Underflow_intr(un17)
   );

   counter_module #(.N(4)) dut4 (
      .Clock(clock), .Reset(reset), .Count_en(en), .Up_Down_Ctrl(dn),
      .Count_out(c4), .Overflow_intr(ov4), .Underflow_intr(un4)
   );

   function automatic int wrap(input int v, input int modulus);
      return (v % modulus + modulus) % modulus;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m17 = 0; m17_ov = 0; m17_un = 0;
         m4  = 0; m4_ov  = 0; m4_un  = 0;
      end else if (!en) begin
         m17_ov = 0; m17_un = 0;
         m4_ov  = 0; m4_un  = 0;
      end else if (!dn) begin
         m17_ov = (m17 == 131071) ? 1 : 0; m17_un = 0; m17 = wrap(m17 + 1, 131072);
         m4_ov  = (m4 == 15) ? 1 : 0;      m4_un  = 0; m4  = wrap(m4 + 1, 16);
      end else begin
         m17_un = (m17 == 0) ? 1 : 0; m17_ov = 0; m17 = wrap(m17 - 1, 131072);
         m4_un  = (m4 == 0) ? 1 : 0;  m4_ov  = 0; m4  = wrap(m4 - 1, 16);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (check_on) begin
         chk("n17 count",     int'(c17),  m17);
         chk("n17 overflow",  int'(ov17), m17_ov);
         chk("n17 underflow", int'(un17), m17_un);
         chk("n4 count",      int'(c4),   m4);
         chk("n4 overflow",   int'(ov4),  m4_ov);
         chk("n4 underflow",  int'(un4),  m4_un);
      end
   end

   task automatic cyc(input logic e, input logic d);
      en = e;
      dn = d;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      // Reset held two edges with enable active
      #2 reset = 1'b1;
      check_on = 1'b1;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      chk("reset count",     int'(c17), 0);
      chk("reset overflow",  int'(ov17), 0);
      chk("reset underflow", int'(un17), 0);
      reset = 1'b0;

      // Up 1,2,3 then down through zero
      cyc(1'b1, 1'b0); chk("up1", int'(c17), 1);
      cyc(1'b1, 1'b0); chk("up2", int'(c17), 2);
      cyc(1'b1, 1'b0); chk("up3", int'(c17), 3);
      chk("up3 no intr", int'(ov17) + int'(un17), 0);
      cyc(1'b1, 1'b1); chk("dn2", int'(c17), 2);
      cyc(1'b1, 1'b1); chk("dn1", int'(c17), 1);
      cyc(1'b1, 1'b1); chk("dn0", int'(c17), 0);
      cyc(1'b1, 1'b1); chk("wrap 1ffff", int'(c17), 'h1FFFF);
      chk("wrap underflow", int'(un17), 1);
      chk("n4 wrap f", int'(c4), 'hF);
      cyc(1'b1, 1'b1); chk("1fffe", int'(c17), 'h1FFFE);
      chk("underflow one cycle", int'(un17), 0);

      // N=4 overflow after 16 up edges
      do_reset();
      for (int k = 1; k <= 15; k++) cyc(1'b1, 1'b0);
      chk("n4 at 15", int'(c4), 15);
      chk("n4 no ovf yet", int'(ov4), 0);
      cyc(1'b1, 1'b0);
      chk("n4 wrap 0", int'(c4), 0);
      chk("n4 overflow", int'(ov4), 1);
      chk("n4 no underflow", int'(un4), 0);
      cyc(1'b1, 1'b0);
      chk("n4 ovf one cycle", int'(ov4), 0);

      // Enable hold at 7
      do_reset();
      for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b1);
         chk("hold 7", int'(c17), 7);
      end
      cyc(1'b1, 1'b0); chk("resume 8", int'(c17), 8);

      // Async reset while counting down at 0x1FFF0
      do_reset();
      for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1);
      chk("at 1fff0", int'(c17), 'h1FFF0);
      #2 reset = 1'b1;
      #1 chk("async clear", int'(c17), 0);
      chk("async clear un", int'(un17), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      cyc(1'b1, 1'b1);
      chk("post reset 1ffff", int'(c17), 'h1FFFF);
      chk("post reset underflow", int'(un17), 1);

      // Random en/dir walk with occasional async reset
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(63) == 0) begin
            #1 reset = 1'b1;
            #1 reset = 1'b0;
         end
         cyc(1'($urandom_range(7) != 0), 1'($urandom_range(1)));
      end

      check_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
